// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encodings and frame-bit levels for the UART1
//               transmitter and its request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_BUSY  = 2'd3
  } arb_state_t;

  localparam logic FRAME_IDLE  = 1'b1;
  localparam logic FRAME_START = 1'b0;
  localparam logic FRAME_STOP  = 1'b1;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector; returns the first valid
//               requester at or after the pointer, searching circularly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [GW-1:0]    ptr,
  output logic [GW-1:0]    grant,
  output logic             any_valid
);

  logic [GW:0]   w_sum;
  logic [GW-1:0] w_idx;

  // Descending scan so the lowest offset from the pointer is written last and wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + (GW + 1)'(i);
      if (w_sum >= (GW + 1)'(N_REQ)) begin
        w_sum = w_sum - (GW + 1)'(N_REQ);
      end
      w_idx = w_sum[GW-1:0];
      if (req_valid[w_idx]) begin
        grant     = w_idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule : rr_picker

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART1 transmitter among byte
//               requesters, sequencing load and tracking each frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ack,
  output logic                       load,
  output logic [7:0]                 tx1,
  output logic                       idle_bit,
  output logic                       start_bit,
  output logic                       stop_bit,
  input  logic                       parallel_in_active,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err_timeout,
  output logic [CNT_W-1:0]           tx_count
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t       r_state;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    r_grant;
  logic [N_REQ-1:0] r_req_ack;
  logic             r_load;
  logic [7:0]       r_tx1;
  logic             r_busy;
  logic             r_err_timeout;
  logic [TW-1:0]    r_wait;
  logic [CNT_W-1:0] r_tx_count;

  logic [GW-1:0]    w_pick;
  logic             w_any_valid;

  rr_picker #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_picker (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .grant     (w_pick),
    .any_valid (w_any_valid)
  );

  // Outputs are set on the transition into a state so they are valid during it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_req_ack     <= '0;
      r_load        <= 1'b0;
      r_tx1         <= '0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_wait        <= '0;
      r_tx_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_state <= S_LOAD;
            r_grant <= w_pick;
            r_tx1   <= req_data[8*w_pick +: 8];
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
            for (int i = 0; i < N_REQ; i++) begin
              r_req_ack[i] <= (GW'(i) == w_pick);
            end
          end
        end
        S_LOAD: begin
          r_state   <= S_START;
          r_load    <= 1'b0;
          r_req_ack <= '0;
          r_wait    <= '0;
          if (r_grant == GW'(N_REQ - 1)) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_grant + 1'b1;
          end
        end
        S_START: begin
          if (parallel_in_active) begin
            r_state <= S_BUSY;
          end else if (r_wait == TW'(TIMEOUT - 1)) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_BUSY: begin
          if (!parallel_in_active) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_tx_count <= r_tx_count + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack     = r_req_ack;
  assign load        = r_load;
  assign tx1         = r_tx1;
  assign grant_id    = r_grant;
  assign busy        = r_busy;
  assign err_timeout = r_err_timeout;
  assign tx_count    = r_tx_count;
  assign idle_bit    = FRAME_IDLE;
  assign start_bit   = FRAME_START;
  assign stop_bit    = FRAME_STOP;

endmodule : uart_tx_arbiter

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a
//               behavioural parallel_in_active source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_REQ-1:0]  req_valid = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]  req_ack;
  logic              load;
  logic [7:0]        tx1;
  logic              idle_bit, start_bit, stop_bit;
  logic              parallel_in_active = 1'b0;
  logic [1:0]        grant_id;
  logic              busy;
  logic              err_timeout;
  logic [CNT_W-1:0]  tx_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_ack            (req_ack),
    .load               (load),
    .tx1                (tx1),
    .idle_bit           (idle_bit),
    .start_bit          (start_bit),
    .stop_bit           (stop_bit),
    .parallel_in_active (parallel_in_active),
    .grant_id           (grant_id),
    .busy               (busy),
    .err_timeout        (err_timeout),
    .tx_count           (tx_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns at the negedge where load is seen high.
  task automatic wait_load(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (load) seen = 1'b1;
    end
    chk({tag, "_load_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Called at the load negedge: UART starts, shifts a few cycles, then goes idle.
  task automatic uart_frame(input string tag);
    bit done = 1'b0;
    parallel_in_active = 1'b1;
    repeat (4) @(negedge clk);
    parallel_in_active = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk({tag, "_frame_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [CNT_W-1:0] cnt_before;

    // 1: reset values
    repeat (2) @(negedge clk);
    chk("rst_load",     {31'd0, load},        32'd0);
    chk("rst_ack",      {28'd0, req_ack},     32'd0);
    chk("rst_tx1",      {24'd0, tx1},         32'd0);
    chk("rst_idle_bit", {31'd0, idle_bit},    32'd1);
    chk("rst_start_bit",{31'd0, start_bit},   32'd0);
    chk("rst_stop_bit", {31'd0, stop_bit},    32'd1);
    chk("rst_grant",    {30'd0, grant_id},    32'd0);
    chk("rst_busy",     {31'd0, busy},        32'd0);
    chk("rst_err",      {31'd0, err_timeout}, 32'd0);
    chk("rst_count",    {16'd0, tx_count},    32'd0);
    rst = 1'b0;

    // 2: single request from requester 2, load exactly one cycle after valid is seen
    req_data[8*2 +: 8] = 8'hA5;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_load",  {31'd0, load},     32'd1);
    chk("single_ack",   {28'd0, req_ack},  32'h4);
    chk("single_tx1",   {24'd0, tx1},      32'hA5);
    chk("single_grant", {30'd0, grant_id}, 32'd2);
    chk("single_busy",  {31'd0, busy},     32'd1);
    req_valid = 4'b0000;
    uart_frame("single");
    chk("single_count", {16'd0, tx_count}, 32'd1);
    chk("single_tx1_hold", {24'd0, tx1},   32'hA5);

    // 3: round robin from a fresh pointer with all requesters held valid
    do_reset();
    for (int i = 0; i < N_REQ; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_load("rr");
      chk("rr_tx1",   {24'd0, tx1},      32'h10 + 32'(k % 4));
      chk("rr_grant", {30'd0, grant_id}, 32'(k % 4));
      chk("rr_ack",   {28'd0, req_ack},  32'd1 << (k % 4));
      parallel_in_active = 1'b1;
      @(negedge clk);
      chk("rr_ack_pulse",  {28'd0, req_ack}, 32'd0);
      chk("rr_load_pulse", {31'd0, load},    32'd0);
      repeat (3) @(negedge clk);
      parallel_in_active = 1'b0;
      @(negedge clk);
    end
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rr_count", {16'd0, tx_count}, 32'd5);

    // 4: UART never starts -> sticky timeout exactly TIMEOUT cycles into S_START
    cnt_before = tx_count;
    req_data[7:0] = 8'h5A;
    req_valid = 4'b0001;
    wait_load("to");
    req_valid = 4'b0000;
    repeat (TIMEOUT) @(negedge clk);
    chk("to_err_early", {31'd0, err_timeout}, 32'd0);
    chk("to_busy_early",{31'd0, busy},        32'd1);
    @(negedge clk);
    chk("to_err",       {31'd0, err_timeout}, 32'd1);
    chk("to_busy",      {31'd0, busy},        32'd0);
    chk("to_count",     {16'd0, tx_count},    {16'd0, cnt_before});
    req_data[8*1 +: 8] = 8'h3C;
    req_valid = 4'b0010;
    wait_load("to_next");
    req_valid = 4'b0000;
    chk("to_next_tx1",  {24'd0, tx1},      32'h3C);
    uart_frame("to_next");
    chk("to_next_count", {16'd0, tx_count}, {16'd0, cnt_before} + 32'd1);
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);

    // 5: reset while the frame is shifting
    req_data[8*3 +: 8] = 8'hC3;
    req_valid = 4'b1000;
    wait_load("mid");
    req_valid = 4'b0000;
    parallel_in_active = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    parallel_in_active = 1'b0;
    chk("mid_busy",  {31'd0, busy},        32'd0);
    chk("mid_count", {16'd0, tx_count},    32'd0);
    chk("mid_err",   {31'd0, err_timeout}, 32'd0);
    req_valid = 4'b0001;
    wait_load("mid_next");
    req_valid = 4'b0000;
    chk("mid_next_grant", {30'd0, grant_id}, 32'd0);
    uart_frame("mid_next");
    chk("mid_next_count", {16'd0, tx_count}, 32'd1);

    // 6: counter wrap
    @(negedge clk);
    force dut.r_tx_count = 16'hFFFF;
    #1;
    release dut.r_tx_count;
    @(negedge clk);
    chk("wrap_preload", {16'd0, tx_count}, 32'hFFFF);
    req_valid = 4'b0010;
    wait_load("wrap");
    req_valid = 4'b0000;
    uart_frame("wrap");
    chk("wrap_count", {16'd0, tx_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

`default_nettype wire
